// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: N-input registered multiplexer with a valid/ready handshake.
// A one-beat skid buffer absorbs the beat that lands while the output is
// stalled. in_ready is a register, so upstream never sees a combinational
// path from out_ready. Illegal select codes produce zero data and set a
// sticky error flag.
module mux_pipe_reg #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  // Pick the addressed input; codes beyond NUM_IN-1 yield zero.
  function automatic logic [WIDTH-1:0] select_beat(
    input logic [NUM_IN*WIDTH-1:0] d,
    input logic [SEL_W-1:0]        s
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(s) == i) r = d[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // True when the select code does not address an existing input.
  function automatic logic sel_illegal(input logic [SEL_W-1:0] s);
    return int'(s) >= NUM_IN;
  endfunction

  logic [WIDTH-1:0] sel_data_p0;
  logic             sel_bad_p0;
  logic             accept_p0;
  logic             out_free;

  logic [WIDTH-1:0] skid_data_p1;
  logic [SEL_W-1:0] skid_sel_p1;
  logic             skid_full;

  logic             load_out_skid;
  logic             load_out_in;
  logic             load_skid;
  logic             skid_full_nxt;
  logic             out_valid_nxt;

  // ---- stage p0: input selection and acceptance ----
  assign sel_data_p0 = select_beat(in_data, in_sel);
  assign sel_bad_p0  = sel_illegal(in_sel);
  assign accept_p0   = in_valid && in_ready;
  assign out_free    = !out_valid || out_ready;

  // Route each beat: stalled output sends new beats to the skid; a freed
  // output drains the skid first so acceptance order is preserved.
  always_comb begin
    load_out_skid = 1'b0;
    load_out_in   = 1'b0;
    load_skid     = 1'b0;
    skid_full_nxt = skid_full;
    out_valid_nxt = out_valid;
    if (out_free) begin
      if (skid_full) begin
        load_out_skid = 1'b1;
        out_valid_nxt = 1'b1;
        load_skid     = accept_p0;
        skid_full_nxt = accept_p0;
      end else if (accept_p0) begin
        load_out_in   = 1'b1;
        out_valid_nxt = 1'b1;
        skid_full_nxt = 1'b0;
      end else begin
        out_valid_nxt = 1'b0;
        skid_full_nxt = 1'b0;
      end
    end else if (accept_p0) begin
      load_skid     = 1'b1;
      skid_full_nxt = 1'b1;
    end
  end

  // ---- stage p1: skid buffer and output register ----
  // Handshake state; in_ready mirrors the next skid occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      skid_full <= skid_full_nxt;
      in_ready  <= !skid_full_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Skid payload; only meaningful while skid_full is set.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_p1 <= sel_data_p0;
      skid_sel_p1  <= in_sel;
    end
  end

  // Output payload; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (load_out_skid) begin
      out_data <= skid_data_p1;
      out_sel  <= skid_sel_p1;
    end else if (load_out_in) begin
      out_data <= sel_data_p0;
      out_sel  <= in_sel;
    end
  end

  // Sticky illegal-select flag; a new error beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (accept_p0 && sel_bad_p0) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule
